arcsin_job_ctrl: RTL and testbench

ARCSIN_JOB_CTRL -- requirements
Module: arcsin_job_ctrl

---
 rtl/arcsin_job_ctrl_if.sv | 25 ++
 rtl/arcsin_job_ctrl.sv | 174 +++++++++++++++++
 tb/tb_arcsin_job_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/arcsin_job_ctrl_if.sv
// Bus and arcsin-core signal bundle for the arcsin job controller.
// The slave side is the controller; the master side is the bus host plus core.
interface arcsin_job_ctrl_if;
  logic        bus_req_i;
  logic        bus_we_i;
  logic [31:0] bus_addr_bi;
  logic [31:0] bus_wdata_bi;
  logic        bus_ack_o;
  logic        bus_resp_o;
  logic [31:0] bus_rdata_bo;
  logic [31:0] core_x_o;
  logic        core_start_o;
  logic        core_done_i;
  logic [31:0] core_y_i;

  modport slave (
    input  bus_req_i, bus_we_i, bus_addr_bi, bus_wdata_bi, core_done_i, core_y_i,
    output bus_ack_o, bus_resp_o, bus_rdata_bo, core_x_o, core_start_o
  );

  modport master (
    output bus_req_i, bus_we_i, bus_addr_bi, bus_wdata_bi, core_done_i, core_y_i,
    input  bus_ack_o, bus_resp_o, bus_rdata_bo, core_x_o, core_start_o
  );
endinterface

// File: rtl/arcsin_job_ctrl.sv
// Memory-mapped job controller: queues operands for an arcsin core, runs one
// job at a time with a timeout, and queues results for in-order readback.
module arcsin_job_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0100,
  parameter int          FIFO_POW  = 2,
  parameter int          TIMEOUT   = 64
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  arcsin_job_ctrl_if.slave bus
);

  localparam int                DEPTH    = 1 << FIFO_POW;
  localparam logic [FIFO_POW:0] FULL_CNT = (FIFO_POW + 1)'(DEPTH);
  localparam logic [31:0]       TMO_LAT  = 32'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, STORE} state_t;

  state_t              state, state_nxt;
  logic [31:0]         offset, rd_mux, status;
  logic                in_map, rd_acc, wr_acc, wr_x, wr_ctrl, rd_y, flush, clr_flags;
  logic [2:0]          reg_sel;
  logic [31:0]         in_mem  [DEPTH];
  logic [31:0]         out_mem [DEPTH];
  logic [FIFO_POW-1:0] in_wr_ptr, in_rd_ptr, out_wr_ptr, out_rd_ptr;
  logic [FIFO_POW:0]   in_cnt, out_cnt;
  logic                in_push, in_pop, in_full, in_empty;
  logic                out_push, out_pop, out_full, out_empty;
  logic                ovf, udf, tmo, ovf_set, udf_set;
  logic                wait_last, job_done, job_tmo, start, busy;
  logic [31:0]         x_reg, result, lat_cnt, lat_reg;
  logic                resp;
  logic [31:0]         rdata;

  // Register decode; anything outside the 5-word window is silently dropped.
  assign offset    = bus.bus_addr_bi - BASE_ADDR;
  assign in_map    = offset < 32'h14;
  assign reg_sel   = offset[4:2];
  assign rd_acc    = bus.bus_req_i && !bus.bus_we_i && in_map;
  assign wr_acc    = bus.bus_req_i && bus.bus_we_i && in_map;
  assign wr_x      = wr_acc && (reg_sel == 3'd0);
  assign wr_ctrl   = wr_acc && (reg_sel == 3'd3);
  assign rd_y      = rd_acc && (reg_sel == 3'd1);
  assign flush     = wr_ctrl && bus.bus_wdata_bi[1];
  assign clr_flags = wr_ctrl && bus.bus_wdata_bi[0];

  assign bus.bus_ack_o = bus.bus_req_i;

  // A push into a full FIFO is still legal when the same cycle pops it.
  assign in_full   = (in_cnt == FULL_CNT);
  assign in_empty  = (in_cnt == '0);
  assign in_pop    = (state == ISSUE) && !flush;
  assign in_push   = wr_x && !flush && (!in_full || in_pop);
  assign ovf_set   = wr_x && !flush && in_full && !in_pop;
  assign out_full  = (out_cnt == FULL_CNT);
  assign out_empty = (out_cnt == '0);
  assign out_pop   = rd_y && !out_empty;
  assign out_push  = (state == STORE) && !flush && (!out_full || out_pop);
  assign udf_set   = rd_y && out_empty;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      in_wr_ptr  <= '0;
      in_rd_ptr  <= '0;
      in_cnt     <= '0;
      out_wr_ptr <= '0;
      out_rd_ptr <= '0;
      out_cnt    <= '0;
    end else if (flush) begin
      in_wr_ptr  <= '0;
      in_rd_ptr  <= '0;
      in_cnt     <= '0;
      out_wr_ptr <= '0;
      out_rd_ptr <= '0;
      out_cnt    <= '0;
    end else begin
      if (in_push)  in_wr_ptr  <= in_wr_ptr + 1'b1;
      if (in_pop)   in_rd_ptr  <= in_rd_ptr + 1'b1;
      if (out_push) out_wr_ptr <= out_wr_ptr + 1'b1;
      if (out_pop)  out_rd_ptr <= out_rd_ptr + 1'b1;
      if (in_push && !in_pop)        in_cnt <= in_cnt + 1'b1;
      else if (in_pop && !in_push)   in_cnt <= in_cnt - 1'b1;
      if (out_push && !out_pop)      out_cnt <= out_cnt + 1'b1;
      else if (out_pop && !out_push) out_cnt <= out_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (in_push)  in_mem[in_wr_ptr]   <= bus.bus_wdata_bi;
    if (out_push) out_mem[out_wr_ptr] <= result;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) state <= IDLE;
    else           state <= state_nxt;
  end

  assign wait_last = (lat_cnt + 32'd1 == TMO_LAT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!in_empty && !out_full) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (bus.core_done_i || wait_last) state_nxt = STORE;
      STORE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_comb begin
    start = (state == ISSUE);
    busy  = (state != IDLE);
  end

  assign bus.core_start_o = start;
  assign bus.core_x_o     = x_reg;
  assign job_done = (state == WAIT) && bus.core_done_i && !flush;
  assign job_tmo  = (state == WAIT) && !bus.core_done_i && wait_last && !flush;

  // Operand is latched on entry to ISSUE so it is already valid alongside start.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      x_reg   <= '0;
      lat_cnt <= '0;
      result  <= '0;
      lat_reg <= '0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
      tmo     <= 1'b0;
    end else begin
      if (state == IDLE && state_nxt == ISSUE) x_reg <= in_mem[in_rd_ptr];
      if (state == ISSUE)     lat_cnt <= '0;
      else if (state == WAIT) lat_cnt <= lat_cnt + 32'd1;
      if (job_done) begin
        result  <= bus.core_y_i;
        lat_reg <= lat_cnt + 32'd1;
      end else if (job_tmo) begin
        result  <= '1;
        lat_reg <= TMO_LAT;
      end
      ovf <= (ovf && !clr_flags) || ovf_set;
      udf <= (udf && !clr_flags) || udf_set;
      tmo <= (tmo && !clr_flags) || job_tmo;
    end
  end

  assign status = {16'h0, 4'(in_cnt), 4'(out_cnt), 4'h0, tmo, udf, ovf, busy};

  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      3'd1:    if (!out_empty) rd_mux = out_mem[out_rd_ptr];
      3'd2:    rd_mux = status;
      3'd4:    rd_mux = lat_reg;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      resp  <= 1'b0;
      rdata <= '0;
    end else begin
      resp  <= rd_acc;
      rdata <= rd_acc ? rd_mux : 32'h0;
    end
  end

  assign bus.bus_resp_o   = resp;
  assign bus.bus_rdata_bo = rdata;

endmodule

// File: tb/tb_arcsin_job_ctrl.sv
// Directed bench for arcsin_job_ctrl: a stub core answers start pulses after a
// programmable delay, and each scenario task checks register readback inline.
module tb_arcsin_job_ctrl;
  localparam logic [31:0] BASE = 32'h8000_0100;
  localparam logic [31:0] A_X = BASE, A_Y = BASE + 32'h4, A_ST = BASE + 32'h8;
  localparam logic [31:0] A_CTRL = BASE + 32'hC, A_LAT = BASE + 32'h10;

  logic        clk = 1'b0;
  logic        arst_n;
  int          checks = 0;
  int          errors = 0;
  logic        use_fixed = 1'b1;
  logic [31:0] core_val = '0;
  int          core_delay = 0;
  int          pulse_req = 0;
  int          pulse_seen = 0;
  int          core_cnt = 0;
  int          starts = 0;
  logic [31:0] seen_x = '0;
  logic [31:0] pend_y = '0;

  arcsin_job_ctrl_if bus();

  arcsin_job_ctrl #(.BASE_ADDR(BASE), .FIFO_POW(2), .TIMEOUT(64)) dut (
    .clk_i   (clk),
    .arst_n_i(arst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] core_fn(input logic [31:0] x);
    return {x[15:0], x[31:16]} ^ 32'h0F0F_0F0F;
  endfunction

  // Stub core: done arrives core_delay cycles after start (0 = never); pulse_req forces a stray done.
  always @(negedge clk) begin
    bus.core_done_i = 1'b0;
    if (pulse_req != pulse_seen) begin
      pulse_seen      = pulse_req;
      bus.core_done_i = 1'b1;
      bus.core_y_i    = core_val;
    end
    if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin
        bus.core_done_i = 1'b1;
        bus.core_y_i    = pend_y;
      end
    end
    if (bus.core_start_o) begin
      starts++;
      seen_x = bus.core_x_o;
      pend_y = use_fixed ? core_val : core_fn(bus.core_x_o);
      if (core_delay > 0) core_cnt = core_delay;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus.bus_req_i    = 1'b1;
    bus.bus_we_i     = 1'b1;
    bus.bus_addr_bi  = addr;
    bus.bus_wdata_bi = data;
    @(negedge clk);
    bus.bus_req_i = 1'b0;
    bus.bus_we_i  = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic resp);
    bus.bus_req_i   = 1'b1;
    bus.bus_we_i    = 1'b0;
    bus.bus_addr_bi = addr;
    @(negedge clk);
    bus.bus_req_i = 1'b0;
    data = bus.bus_rdata_bo;
    resp = bus.bus_resp_o;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        r;
    arst_n          = 1'b0;
    bus.bus_req_i   = 1'b1;
    bus.bus_we_i    = 1'b0;
    bus.bus_addr_bi = A_ST;
    repeat (2) @(negedge clk);
    checks++; if (bus.bus_ack_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_ack_hi: got %b expected 1", bus.bus_ack_o); end
    checks++; if (bus.bus_resp_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp: got %b expected 0", bus.bus_resp_o); end
    checks++; if (bus.bus_rdata_bo !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 0", bus.bus_rdata_bo); end
    checks++; if (bus.core_start_o !== 1'b0 || bus.core_x_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_core: got start %b x %h expected 0 0", bus.core_start_o, bus.core_x_o); end
    bus.bus_req_i = 1'b0;
    #1;
    checks++; if (bus.bus_ack_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack_lo: got %b expected 0", bus.bus_ack_o); end
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    bus_read(A_ST, d, r);
    checks++; if (r !== 1'b1 || d !== 32'h0) begin errors++; $display("[TB] FAIL reset_status: got resp %b data %h expected 1 00000000", r, d); end
    bus_read(A_LAT, d, r);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_lat: got %h expected 0", d); end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic        r;
    int          s0;
    s0 = starts; use_fixed = 1'b1; core_val = 32'h1234_5678; core_delay = 3;
    bus_write(A_X, 32'h4000_0000);
    idle(12);
    checks++; if (seen_x !== 32'h4000_0000 || starts != s0 + 1) begin errors++; $display("[TB] FAIL basic_issue: got x %h starts %0d expected 40000000 %0d", seen_x, starts - s0, 1); end
    bus_read(A_Y, d, r);
    checks++; if (r !== 1'b1 || d !== 32'h1234_5678) begin errors++; $display("[TB] FAIL basic_y: got resp %b data %h expected 1 12345678", r, d); end
    bus_read(A_LAT, d, r);
    checks++; if (d !== 32'd3) begin errors++; $display("[TB] FAIL basic_lat: got %0d expected 3", d); end
    bus_read(A_ST, d, r);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL basic_status: got %h expected 00000000", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic        r;
    logic [31:0] xs [5] = '{32'h0000_0001, 32'hCAFE_0002, 32'h1357_9BDF, 32'h8000_0000, 32'hFFFF_0000};
    use_fixed = 1'b0; core_delay = 1;
    for (int i = 0; i < 5; i++) bus_write(A_X, xs[i]);
    idle(30);
    // Output FIFO full: fifth job must wait in the input FIFO with FSM idle.
    bus_read(A_ST, d, r);
    checks++; if (d !== 32'h0000_1400) begin errors++; $display("[TB] FAIL b2b_status_full: got %h expected 00001400", d); end
    for (int i = 0; i < 4; i++) begin
      bus_read(A_Y, d, r);
      checks++; if (r !== 1'b1 || d !== core_fn(xs[i])) begin errors++; $display("[TB] FAIL b2b_y%0d: got %h expected %h", i, d, core_fn(xs[i])); end
    end
    idle(8);
    bus_read(A_Y, d, r);
    checks++; if (d !== core_fn(xs[4])) begin errors++; $display("[TB] FAIL b2b_y4: got %h expected %h", d, core_fn(xs[4])); end
    bus_read(A_Y, d, r);
    checks++; if (r !== 1'b1 || d !== 32'h0) begin errors++; $display("[TB] FAIL udf_y: got resp %b data %h expected 1 00000000", r, d); end
    bus_read(A_ST, d, r);
    checks++; if (d !== 32'h0000_0004) begin errors++; $display("[TB] FAIL udf_status: got %h expected 00000004", d); end
    bus_write(A_CTRL, 32'h1);
    bus_read(A_LAT, d, r);
    checks++; if (d !== 32'd1) begin errors++; $display("[TB] FAIL b2b_lat: got %0d expected 1", d); end
    bus_read(BASE + 32'h20, d, r);
    checks++; if (r !== 1'b0 || d !== 32'h0) begin errors++; $display("[TB] FAIL unmapped_20: got resp %b data %h expected 0 00000000", r, d); end
    bus_read(BASE + 32'h14, d, r);
    checks++; if (r !== 1'b0) begin errors++; $display("[TB] FAIL unmapped_14: got resp %b expected 0", r); end
    bus_write(BASE + 32'h14, 32'h5555_AAAA);
    bus_read(A_ST, d, r);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL unmapped_wr_status: got %h expected 00000000", d); end
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    logic        r;
    use_fixed = 1'b0; core_delay = 0;
    bus_write(A_X, 32'h3333_4444);
    idle(75);
    bus_read(A_Y, d, r);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL tmo_y: got %h expected ffffffff", d); end
    bus_read(A_LAT, d, r);
    checks++; if (d !== 32'd64) begin errors++; $display("[TB] FAIL tmo_lat: got %0d expected 64", d); end
    bus_read(A_ST, d, r);
    checks++; if (d !== 32'h0000_0008) begin errors++; $display("[TB] FAIL tmo_status: got %h expected 00000008", d); end
    bus_write(A_CTRL, 32'h1);
    core_delay = 63;
    bus_write(A_X, 32'h0102_0304);
    idle(75);
    bus_read(A_Y, d, r);
    checks++; if (d !== core_fn(32'h0102_0304)) begin errors++; $display("[TB] FAIL late63_y: got %h expected %h", d, core_fn(32'h0102_0304)); end
    bus_read(A_LAT, d, r);
    checks++; if (d !== 32'd63) begin errors++; $display("[TB] FAIL late63_lat: got %0d expected 63", d); end
    bus_read(A_ST, d, r);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL late63_status: got %h expected 00000000", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic        r;
    use_fixed = 1'b1; core_val = 32'h0; core_delay = 0;
    bus_write(A_X, 32'h0000_0001);
    idle(4);
    for (int i = 0; i < 5; i++) bus_write(A_X, 32'h100 + i);
    bus_read(A_ST, d, r);
    checks++; if (d !== 32'h0000_4003) begin errors++; $display("[TB] FAIL ovf_status: got %h expected 00004003", d); end
    bus_write(A_CTRL, 32'h1);
    bus_read(A_ST, d, r);
    checks++; if (d !== 32'h0000_4001) begin errors++; $display("[TB] FAIL ovf_clear: got %h expected 00004001", d); end
    bus_write(A_CTRL, 32'h2);
    bus_read(A_ST, d, r);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL ovf_flush: got %h expected 00000000", d); end
  endtask

  task automatic test_flush();
    logic [31:0] d;
    logic        r;
    int          s0;
    use_fixed = 1'b1; core_val = 32'hDEAD_BEEF; core_delay = 0;
    for (int i = 0; i < 4; i++) bus_write(A_X, 32'h200 + i);
    idle(2);
    bus_read(A_ST, d, r);
    checks++; if (d !== 32'h0000_3001) begin errors++; $display("[TB] FAIL flush_pre_status: got %h expected 00003001", d); end
    bus_write(A_CTRL, 32'h2);
    s0 = starts;
    pulse_req++;
    idle(6);
    bus_read(A_ST, d, r);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL flush_status: got %h expected 00000000", d); end
    checks++; if (starts != s0) begin errors++; $display("[TB] FAIL flush_starts: got %0d expected %0d", starts, s0); end
    bus_read(A_LAT, d, r);
    checks++; if (d !== 32'd63) begin errors++; $display("[TB] FAIL flush_lat: got %0d expected 63", d); end
  endtask

  task automatic test_reset_mid_job();
    logic [31:0] d;
    logic        r;
    use_fixed = 1'b0; core_delay = 0;
    bus_write(A_X, 32'hAAAA_5555);
    idle(5);
    bus_read(A_ST, d, r);
    checks++; if (r !== 1'b1 || d !== 32'h0000_0001) begin errors++; $display("[TB] FAIL mid_pre_status: got resp %b data %h expected 1 00000001", r, d); end
    arst_n = 1'b0;
    #1;
    checks++; if (bus.bus_resp_o !== 1'b0 || bus.bus_rdata_bo !== 32'h0) begin errors++; $display("[TB] FAIL mid_reset_bus: got resp %b data %h expected 0 00000000", bus.bus_resp_o, bus.bus_rdata_bo); end
    checks++; if (bus.core_x_o !== 32'h0 || bus.core_start_o !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_core: got x %h start %b expected 0 0", bus.core_x_o, bus.core_start_o); end
    @(negedge clk);
    arst_n = 1'b1;
    idle(3);
    bus_read(A_ST, d, r);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL mid_post_status: got %h expected 00000000", d); end
    bus_read(A_LAT, d, r);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL mid_post_lat: got %0d expected 0", d); end
    core_delay = 2;
    bus_write(A_X, 32'h1111_2222);
    idle(10);
    bus_read(A_Y, d, r);
    checks++; if (r !== 1'b1 || d !== core_fn(32'h1111_2222)) begin errors++; $display("[TB] FAIL mid_job_y: got %h expected %h", d, core_fn(32'h1111_2222)); end
    bus_read(A_LAT, d, r);
    checks++; if (d !== 32'd2) begin errors++; $display("[TB] FAIL mid_job_lat: got %0d expected 2", d); end
    bus_read(A_ST, d, r);
    checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL mid_job_status: got %h expected 00000000", d); end
  endtask

  initial begin
    arst_n           = 1'b0;
    bus.bus_req_i    = 1'b0;
    bus.bus_we_i     = 1'b0;
    bus.bus_addr_bi  = '0;
    bus.bus_wdata_bi = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_overflow();
    test_flush();
    test_reset_mid_job();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule
